// File: rtl/comp_run_ctrl.sv
// Load/run/capture sequencer for the comp core: streams a program image in, runs to halt or timeout, buffers outputs.
// Optional build macro COMP_RUN_CTRL_ZERO_FILL_EN: zero the unwritten tail of program memory before running.
module comp_run_ctrl #(
    parameter int MEM_WORDS      = 256,
    parameter int OUT_DEPTH      = 32,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        core_rst,
    output logic [31:0] oob_wr_addr,
    output logic [31:0] oob_wr_data,
    output logic        oob_wen,
    input  logic [31:0] core_out,
    input  logic        core_outen,
    input  logic        core_outflen,
    input  logic        core_halt,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_is_float,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic        overflow,
    output logic [31:0] run_cycles
);
    localparam int AW = $clog2(MEM_WORDS) + 1;
    localparam int PW = $clog2(OUT_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WORDS - 1);
    localparam logic [AW-1:0] MEM_LIM   = AW'(MEM_WORDS);
    localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW+1)'(OUT_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          fill_q;
    logic          accept, last_acc, begin_load;

    assign load_ready = (state_q == LOAD) && !fill_q && (addr_q < MEM_LIM);
    assign accept     = load_valid && load_ready;
    assign last_acc   = accept && (load_last || addr_q == LAST_ADDR);
    assign begin_load = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d  = state_q;
        core_rst = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
`ifdef COMP_RUN_CTRL_ZERO_FILL_EN
                if (fill_q) begin
                    if (addr_q == LAST_ADDR) state_d = SETTLE;
                end else if (last_acc && addr_q == LAST_ADDR) begin
                    state_d = SETTLE;
                end
`else
                if (last_acc) state_d = SETTLE;
`endif
            end
            SETTLE: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                core_rst = 1'b0;
                if (core_halt || run_cycles == TO_LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef COMP_RUN_CTRL_ZERO_FILL_EN
    // Set after an early last word; the address counter then walks the tail writing zeros.
    always_ff @(posedge clk) begin
        if (rst || begin_load)                       fill_q <= 1'b0;
        else if (last_acc && addr_q != LAST_ADDR)    fill_q <= 1'b1;
        else if (fill_q && addr_q == LAST_ADDR)      fill_q <= 1'b0;
    end
`else
    assign fill_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            oob_wen     <= 1'b0;
            oob_wr_addr <= '0;
            oob_wr_data <= '0;
            timed_out   <= 1'b0;
            run_cycles  <= '0;
        end else begin
            state_q <= state_d;
            oob_wen <= 1'b0;
            if (begin_load) begin
                addr_q     <= '0;
                timed_out  <= 1'b0;
                run_cycles <= '0;
            end
            if (accept) begin
                oob_wen     <= 1'b1;
                oob_wr_addr <= 32'(addr_q);
                oob_wr_data <= load_data;
                addr_q      <= addr_q + AW'(1);
            end
`ifdef COMP_RUN_CTRL_ZERO_FILL_EN
            if (fill_q) begin
                oob_wen     <= 1'b1;
                oob_wr_addr <= 32'(addr_q);
                oob_wr_data <= '0;
                addr_q      <= addr_q + AW'(1);
            end
`endif
            if (state_q == RUN) begin
                run_cycles <= run_cycles + 32'd1;
                if (!core_halt && run_cycles == TO_LAST) timed_out <= 1'b1;
            end
        end
    end

    logic [32:0]   mem_q [OUT_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic          push_req, pop, full, do_push;

    assign push_req = (state_q == RUN) && (core_outen || core_outflen);
    assign pop      = rd_valid && rd_ready;
    assign full     = (count_q == FIFO_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst || begin_load) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (pop)     rptr_q <= rptr_q + PW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= {core_outflen, core_out};
    end

    assign rd_valid               = (count_q != '0);
    assign {rd_is_float, rd_data} = mem_q[rptr_q];
endmodule

// File: tb/tb_comp_run_ctrl.sv
// Randomized bench for comp_run_ctrl: load/run/drain sequences checked against a queue-based reference model.
module tb_comp_run_ctrl;
    localparam int MW    = 8;
    localparam int DEPTH = 32;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst, start, load_valid, load_ready, load_last;
    logic [31:0] load_data;
    logic        core_rst, oob_wen;
    logic [31:0] oob_wr_addr, oob_wr_data;
    logic [31:0] core_out;
    logic        core_outen, core_outflen, core_halt;
    logic        rd_valid, rd_ready, rd_is_float;
    logic [31:0] rd_data;
    logic        busy, done, timed_out, overflow;
    logic [31:0] run_cycles;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] model_q [$];
    bit          exp_ovf, exp_to;
    logic [31:0] prog_tbl [4] = '{32'h00000013, 32'h00100093, 32'h00000000, 32'hDEADBEEF};

    always #5 clk = ~clk;

    comp_run_ctrl #(.MEM_WORDS(MW), .OUT_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .core_rst(core_rst), .oob_wr_addr(oob_wr_addr), .oob_wr_data(oob_wr_data), .oob_wen(oob_wen),
        .core_out(core_out), .core_outen(core_outen), .core_outflen(core_outflen), .core_halt(core_halt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_is_float(rd_is_float),
        .busy(busy), .done(done), .timed_out(timed_out), .overflow(overflow), .run_cycles(run_cycles)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start = 0; load_valid = 0; load_last = 0; load_data = '0;
        core_out = '0; core_outen = 0; core_outflen = 0; core_halt = 0; rd_ready = 0;
    endtask

    task automatic check_head;
        check_eq("rd_valid", rd_valid, model_q.size() != 0);
        if (model_q.size() != 0) begin
            check_eq("rd_data", rd_data, model_q[0][31:0]);
            check_eq("rd_is_float", rd_is_float, model_q[0][32]);
        end
    endtask

    // mode 0: random strobes/pops, halt at halt_at; 1: overflow pattern; 2: fixed two-word output
    task automatic do_run(input int n_words, input bit use_last, input int mode, input int halt_at, input bit drain);
        int idx, c, guard;
        bit acc, fin, halt, stb, pop, end_run;
        start = 1; tick; start = 0;
        model_q.delete(); exp_ovf = 0; exp_to = 0;
        check_eq("start_busy", busy, 1);
        check_eq("start_done", done, 0);
        check_eq("start_core_rst", core_rst, 1);
        check_eq("start_fifo_clear", rd_valid, 0);
        check_eq("start_run_cycles", run_cycles, 0);
        check_eq("start_timed_out", timed_out, 0);
        check_eq("start_overflow", overflow, 0);

        idx = 0; fin = 0; guard = 0;
        while (!fin && guard < 200) begin
            guard++;
            check_eq("load_ready", load_ready, 1);
            acc        = ($urandom_range(0, 3) != 0);
            load_valid = acc;
            load_data  = (mode == 2 && idx < 4) ? prog_tbl[idx] : $urandom;
            load_last  = use_last && (idx == n_words - 1);
            tick;
            check_eq("oob_wen", oob_wen, acc);
            if (acc) begin
                check_eq("oob_addr", oob_wr_addr, idx);
                check_eq("oob_data", oob_wr_data, load_data);
                idx++;
                fin = load_last || (idx == MW);
            end
        end
        if (!fin) check_eq("load_bound", idx, n_words);
        load_valid = 0; load_last = 0;
        check_eq("load_ready_end", load_ready, 0);
        check_eq("settle_core_rst", core_rst, 1);
`ifdef COMP_RUN_CTRL_ZERO_FILL_EN
        for (int a = idx; a < MW; a++) begin
            tick;
            check_eq("fill_wen", oob_wen, 1);
            check_eq("fill_addr", oob_wr_addr, a);
            check_eq("fill_data", oob_wr_data, 0);
            check_eq("fill_ready", load_ready, 0);
            check_eq("fill_core_rst", core_rst, 1);
        end
`endif
        tick;
        check_eq("settle_wen", oob_wen, 0);

        c = 0; end_run = 0;
        while (!end_run) begin
            check_eq("run_core_rst", core_rst, 0);
            check_eq("run_cycles", run_cycles, c);
            check_eq("overflow_run", overflow, exp_ovf);
            check_head();
            start = 0; core_outen = 0; core_outflen = 0; halt = 0; rd_ready = 0;
            core_out = $urandom;
            case (mode)
                1: begin
                    core_outen = (c <= 33);
                    core_out   = 32'(c);
                    rd_ready   = (c == 33);
                    halt       = (c == 34);
                end
                2: begin
                    if (c == 0) begin core_outen = 1; core_out = 32'h0000002A; end
                    if (c == 1) begin core_outflen = 1; core_out = 32'h3F800000; end
                    halt = (c == 2);
                end
                default: begin
                    core_outen   = ($urandom_range(0, 2) == 0);
                    core_outflen = ($urandom_range(0, 2) == 0);
                    rd_ready     = $urandom_range(0, 1);
                    halt         = (c == halt_at);
                    start        = ($urandom_range(0, 15) == 0);
                end
            endcase
            core_halt = halt;
            stb = core_outen | core_outflen;
            pop = rd_ready && model_q.size() != 0;
            if (pop) void'(model_q.pop_front());
            if (stb) begin
                if (model_q.size() < DEPTH) model_q.push_back({core_outflen, core_out});
                else exp_ovf = 1;
            end
            end_run = halt || (c == TMO - 1);
            if (!halt && c == TMO - 1) exp_to = 1;
            tick;
            c++;
        end
        idle_inputs();

        check_eq("done", done, 1);
        check_eq("done_busy", busy, 0);
        check_eq("done_core_rst", core_rst, 1);
        check_eq("timed_out", timed_out, exp_to);
        check_eq("overflow", overflow, exp_ovf);
        check_eq("run_cycles_final", run_cycles, c);

        if (drain) begin
            guard = 0;
            while (model_q.size() != 0 && guard < 4 * DEPTH + 40) begin
                guard++;
                check_head();
                check_eq("drain_done", done, 1);
                rd_ready   = $urandom_range(0, 1);
                core_outen = $urandom_range(0, 1);
                core_out   = $urandom;
                if (rd_ready && model_q.size() != 0) void'(model_q.pop_front());
                tick;
            end
            idle_inputs();
            check_head();
        end
    endtask

    task automatic reset_mid_load;
        start = 1; tick; start = 0;
        load_valid = 1; load_data = $urandom; tick;
        load_data = $urandom; tick;
        load_valid = 0; rst = 1; tick; rst = 0;
        check_eq("mid_rst_core_rst", core_rst, 1);
        check_eq("mid_rst_wen", oob_wen, 0);
        check_eq("mid_rst_ready", load_ready, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_rd_valid", rd_valid, 0);
        model_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1;
        tick; tick;
        check_eq("rst_core_rst", core_rst, 1);
        check_eq("rst_wen", oob_wen, 0);
        check_eq("rst_addr", oob_wr_addr, 0);
        check_eq("rst_data", oob_wr_data, 0);
        check_eq("rst_ready", load_ready, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_timed_out", timed_out, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_run_cycles", run_cycles, 0);
        rst = 0;
        tick;

        do_run(4, 1, 2, 0, 1);
        do_run(3, 1, 0, TMO + 50, 1);
        do_run(0, 0, 0, TMO - 1, 1);
        do_run(3, 1, 1, 0, 0);
        do_run(2, 1, 0, 10, 1);
        reset_mid_load();
        do_run(5, 1, 0, 20, 1);
        for (int i = 0; i < 6; i++)
            do_run($urandom_range(1, MW), 1'($urandom_range(0, 1)), 0, $urandom_range(0, 120), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
